ref_row_streamer: RTL

- Producer side of the interpolator's row input: fetches a reference pixel block from frame memory one row at a time.
- Emits each row as one 15-pixel, 120-bit word, the format the subpixel_interpolation input shift register consumes.
- Per-row flow: reads three aligned 8-pixel memory words, funnel-shifts them to the block's pixel offset, presents the row with a valid/ready handshake.
- Sits between the frame-memory read port and subpixel_interpolation.in_row.

---
 rtl/ref_row_streamer_pkg.sv | 21 ++
 rtl/ref_row_streamer_row_aligner.sv | 16 +
 rtl/ref_row_streamer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ref_row_streamer_pkg.sv
// Shared constants and FSM encoding for the reference row streamer.
// Pixel/word geometry of the 15-pixel interpolator row format.
package ref_row_streamer_pkg;

    localparam int PIX_W       = 8;
    localparam int ROW_PIX     = 15;
    localparam int WORD_PIX    = 8;
    localparam int ROW_BITS    = ROW_PIX * PIX_W;
    localparam int FETCH_WORDS = 3;
    localparam int WORD_BITS   = WORD_PIX * PIX_W;
    localparam int FUNNEL_BITS = FETCH_WORDS * WORD_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ALIGN,
        S_PRESENT,
        S_FINISH
    } state_e;

endpackage

// File: rtl/ref_row_streamer_row_aligner.sv
// Funnel shifter: picks 15 consecutive pixels out of three memory words
// starting at the block's pixel offset inside the first word.
module row_aligner
    import ref_row_streamer_pkg::*;
(
    input  logic [FUNNEL_BITS-1:0] words_i,
    input  logic [2:0]             off_i,
    output logic [ROW_BITS-1:0]    row_o
);

    // Offset in pixels becomes a bit offset of off*8 into {w2,w1,w0}.
    always_comb begin
        row_o = words_i[{off_i, 3'b000} +: ROW_BITS];
    end

endmodule

// File: rtl/ref_row_streamer.sv
// Fetches a reference block row by row from frame memory and presents
// each row as one 120-bit word over a valid/ready handshake.
module ref_row_streamer
    import ref_row_streamer_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int FRAME_W_WORDS = 4,
    parameter int NUM_ROWS      = 15,
    parameter int COORD_W       = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [COORD_W-1:0]   blk_x,
    input  logic [COORD_W-1:0]   blk_y,
    output logic                 mem_rd_en,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [WORD_BITS-1:0] mem_rd_data,
    output logic [ROW_BITS-1:0]  in_row,
    output logic                 row_valid,
    input  logic                 row_ready,
    output logic                 busy,
    output logic                 done
);

    localparam int RW = $clog2(NUM_ROWS);
    localparam logic [RW-1:0] LAST_ROW = RW'(NUM_ROWS - 1);
    localparam logic [1:0] LAST_K = 2'(FETCH_WORDS - 1);

    state_e                state_q, state_d;
    logic [1:0]            k_q, k_d;
    logic [RW-1:0]         r_q, r_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic [2:0]            off_q, off_d;
    logic [WORD_BITS-1:0]  w0_q, w0_d;
    logic [WORD_BITS-1:0]  w1_q, w1_d;
    logic [WORD_BITS-1:0]  w2_q, w2_d;
    logic [ROW_BITS-1:0]   in_row_q, in_row_d;
    logic [ROW_BITS-1:0]   aligned;
    logic [ADDR_W-1:0]     start_base;
    logic                  rd_en, valid, done_p;

    // base_q tracks the first word of the current row, so it starts at
    // the block origin and steps by one frame pitch per row.
    assign start_base = ADDR_W'(blk_y) * ADDR_W'(FRAME_W_WORDS)
                      + ADDR_W'(blk_x[COORD_W-1:3]);

    // w2 is taken straight from the read port in ALIGN so the row is
    // registered in the same cycle the last word arrives.
    row_aligner u_align (
        .words_i ({mem_rd_data, w1_q, w0_q}),
        .off_i   (off_q),
        .row_o   (aligned)
    );

    // Next-state logic, word capture and handshake outputs.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        r_d      = r_q;
        base_d   = base_q;
        off_d    = off_q;
        w0_d     = w0_q;
        w1_d     = w1_q;
        w2_d     = w2_q;
        in_row_d = in_row_q;
        rd_en    = 1'b0;
        valid    = 1'b0;
        done_p   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = start_base;
                    off_d   = blk_x[2:0];
                    r_d     = '0;
                    k_d     = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                rd_en = 1'b1;
                if (k_q == 2'd1) w0_d = mem_rd_data;
                if (k_q == 2'd2) w1_d = mem_rd_data;
                if (k_q == LAST_K) begin
                    k_d     = '0;
                    state_d = S_ALIGN;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            S_ALIGN: begin
                w2_d     = mem_rd_data;
                in_row_d = aligned;
                state_d  = S_PRESENT;
            end
            S_PRESENT: begin
                valid = 1'b1;
                if (row_ready) begin
                    if (r_q == LAST_ROW) begin
                        state_d = S_FINISH;
                    end else begin
                        r_d     = r_q + RW'(1);
                        base_d  = base_q + ADDR_W'(FRAME_W_WORDS);
                        state_d = S_FETCH;
                    end
                end
            end
            S_FINISH: begin
                done_p  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any block in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            r_q      <= '0;
            base_q   <= '0;
            off_q    <= '0;
            w0_q     <= '0;
            w1_q     <= '0;
            w2_q     <= '0;
            in_row_q <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            r_q      <= r_d;
            base_q   <= base_d;
            off_q    <= off_d;
            w0_q     <= w0_d;
            w1_q     <= w1_d;
            w2_q     <= w2_d;
            in_row_q <= in_row_d;
        end
    end

    assign mem_rd_en = rd_en;
    assign mem_addr  = rd_en ? base_q + ADDR_W'(k_q) : '0;
    assign in_row    = in_row_q;
    assign row_valid = valid;
    assign done      = done_p;
    assign busy      = (state_q != S_IDLE);

endmodule
